// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter feeding a single-entry registered output stage.
// The grant rotates to the channel after the last winner; in_ready is a combinational grant.
module rr_arb_mux_4_1 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  localparam int unsigned NCH = 4;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic [1:0]   out_sel_q,   out_sel_d;
  logic [1:0]   ptr_q,       ptr_d;

  logic         load_en;
  logic         win_found;
  logic [1:0]   win_idx;
  logic [1:0]   cand;
  logic [W-1:0] win_data;

  assign load_en = !out_valid_q || out_ready;

  // Scan from lowest priority to highest so the closest valid channel to ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (in_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && load_en && win_found) begin
      in_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (win_found) begin
        out_valid_d = 1'b1;
        out_data_d  = win_data;
        out_sel_d   = win_idx;
        ptr_d       = win_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr_q       <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
